fp_result_fifo: RTL

FP_RESULT_FIFO -- requirements
Module: fp_result_fifo

---
 rtl/fp_result_fifo.sv | 96 +++++++++
 1 files changed

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: show-ahead FIFO for packed FP results and their exception
// flags, with sticky OR-accumulation of flags across accepted results.
// ready_out depends only on registered occupancy, so a pop cannot raise it
// in the same cycle. The head entry is driven combinationally, which gives a
// read latency of zero cycles.
module fp_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic [31:0]                result_in,
  input  logic [4:0]                 flags_in,
  input  logic                       pop,
  output logic                       valid_out,
  output logic [31:0]                result_out,
  output logic [4:0]                 flags_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic [4:0]                 sticky_flags,
  input  logic                       clear_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 37;

  // Storage is not reset; entries are only visible while the FIFO is non-empty.
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [4:0]    r_sticky;

  logic          w_ready;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  assign w_ready = (r_count < CW'(DEPTH));
  assign w_valid = (r_count != {CW{1'b0}});
  assign w_push  = valid_in & w_ready;
  assign w_pop   = pop & w_valid;
  assign w_head  = r_mem[r_rd_ptr];

  // Write the accepted result and flags into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= {result_in, flags_in};
    end
  end

  // Pointers, occupancy and sticky flags; power-of-two depth makes the
  // pointer increment wrap from DEPTH-1 to 0 on its own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_sticky <= 5'b00000;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_sticky <= (clear_flags ? 5'b00000 : r_sticky) | (w_push ? flags_in : 5'b00000);
    end
  end

  // Present the head entry, forced to zero while the FIFO is empty.
  always_comb begin
    result_out = 32'h0000_0000;
    flags_out  = 5'b00000;
    if (w_valid) begin
      result_out = w_head[36:5];
      flags_out  = w_head[4:0];
    end else begin
      result_out = 32'h0000_0000;
      flags_out  = 5'b00000;
    end
  end

  assign ready_out    = w_ready;
  assign valid_out    = w_valid;
  assign count        = r_count;
  assign sticky_flags = r_sticky;

endmodule
